// File: rtl/hex_accum_fsm.sv
// hex_accum_fsm: serial hex calculator control FSM.
// Parses "<op>[hex]CR LF" lines from the UART, keeps a modulo accumulator
// and answers with a ROM message, the accumulator in ASCII hex, then CR LF.
// Ports:
//   CLK, RST_N         clock (rising edge), async active-low reset
//   RX_DATA_EN/_R      rx byte strobe, {stop err, parity err, byte}
//   HEX_FLG            rx byte is a hex digit (external decoder)
//   DC_HEX_DATA        decoded digit value of the rx byte
//   DC_ASCII_DATA      ASCII of HEX_DATA (external encoder)
//   DATA               ROM byte at ADDR (combinational)
//   TX_RDY_R           tx took TX_DATA_T, wants the next byte
//   TX_RDY_T           response in progress
//   TX_DATA_T          byte offered to tx
//   ASCII_DATA         rx byte passthrough to the hex decoder
//   HEX_DATA           accumulator nibble at the digit index
//   ADDR               ROM address
module hex_accum_fsm #(
   parameter int N_DIGITS = 16,
   parameter int SLOT_LG  = 4
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               RX_DATA_EN,
   input  logic [9:0]         RX_DATA_R,
   input  logic               HEX_FLG,
   input  logic [3:0]         DC_HEX_DATA,
   input  logic [7:0]         DC_ASCII_DATA,
   input  logic [7:0]         DATA,
   input  logic               TX_RDY_R,
   output logic               TX_RDY_T,
   output logic [7:0]         TX_DATA_T,
   output logic [7:0]         ASCII_DATA,
   output logic [3:0]         HEX_DATA,
   output logic [SLOT_LG+2:0] ADDR
);

   localparam int W   = 4 * (N_DIGITS + 1);
   localparam int OPW = 4 * N_DIGITS;
   localparam int AW  = SLOT_LG + 3;
   localparam int CW  = $clog2(N_DIGITS + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_RDIG, S_RCR, S_RLF,
      S_TLOAD, S_TMSG, S_TDIG, S_TCR, S_TLF
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD, OP_SUB, OP_CLR, OP_SHOW
   } op_t;

   state_t           state_q, state_nx;
   op_t              op_q, op_nx;
   logic [W-1:0]     acc_q, acc_nx;
   logic [OPW-1:0]   opnd_q, opnd_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic [CW-1:0]    idx_q, idx_nx;
   logic             res_q, res_nx;
   logic             tx_rdy_q, tx_rdy_nx;
   logic [7:0]       tx_data_q, tx_data_nx;
   logic [AW-1:0]    addr_q, addr_nx;

   logic             err;
   logic [2:0]       err_slot;
   logic             exec;
   logic             dig;

   logic [7:0] rx_b;
   logic       rx_perr;
   logic       is_add, is_sub, is_clr, is_show;
   logic       is_cr, is_lf;
   logic       msg_end, cnt_full, idx_last, tx_go;

   assign rx_b    = RX_DATA_R[7:0];
   assign rx_perr = |RX_DATA_R[9:8];
   assign is_add  = rx_b == 8'h2B;
   assign is_sub  = rx_b == 8'h2D;
   assign is_clr  = (rx_b == 8'h43) || (rx_b == 8'h63);
   assign is_show = rx_b == 8'h3D;
   assign is_cr   = rx_b == 8'h0D;
   assign is_lf   = rx_b == 8'h0A;

   // message ends on a 00 byte or when ADDR has stepped past the slot
   assign msg_end  = (DATA == 8'h00) ||
                     (addr_q[SLOT_LG-1:0] == '0);
   assign cnt_full = cnt_q == CW'(N_DIGITS);
   assign idx_last = idx_q == CW'(N_DIGITS + 1);
   assign tx_go    = TX_RDY_R && tx_rdy_q;

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ADD;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         res_q     <= 1'b0;
         tx_rdy_q  <= 1'b0;
         tx_data_q <= 8'h00;
         addr_q    <= '0;
      end else begin
         state_q   <= state_nx;
         op_q      <= op_nx;
         acc_q     <= acc_nx;
         opnd_q    <= opnd_nx;
         cnt_q     <= cnt_nx;
         idx_q     <= idx_nx;
         res_q     <= res_nx;
         tx_rdy_q  <= tx_rdy_nx;
         tx_data_q <= tx_data_nx;
         addr_q    <= addr_nx;
      end
   end

   // next state
   always_comb begin
      state_nx = state_q;
      err      = 1'b0;
      err_slot = 3'd0;
      exec     = 1'b0;
      dig      = 1'b0;
      unique case (state_q)
         S_IDLE, S_RDIG, S_RCR, S_RLF: begin
            if (RX_DATA_EN) begin
               if (rx_perr) begin
                  err      = 1'b1;
                  err_slot = {1'b0, RX_DATA_R[9:8]};
               end else begin
                  unique case (state_q)
                     S_IDLE: begin
                        unique case (1'b1)
                           is_add, is_sub:  state_nx = S_RDIG;
                           is_clr, is_show: state_nx = S_RCR;
                           default: begin
                              err      = 1'b1;
                              err_slot = 3'd4;
                           end
                        endcase
                     end
                     S_RDIG: begin
                        if (HEX_FLG) begin
                           if (cnt_full) begin
                              err      = 1'b1;
                              err_slot = 3'd5;
                           end else begin
                              dig = 1'b1;
                           end
                        end else if (is_cr) begin
                           if (cnt_q == '0) begin
                              err      = 1'b1;
                              err_slot = 3'd6;
                           end else begin
                              state_nx = S_RLF;
                           end
                        end else begin
                           err      = 1'b1;
                           err_slot = 3'd4;
                        end
                     end
                     S_RCR: begin
                        if (is_cr) begin
                           state_nx = S_RLF;
                        end else begin
                           err      = 1'b1;
                           err_slot = 3'd4;
                        end
                     end
                     default: begin
                        if (is_lf) begin
                           exec     = 1'b1;
                           state_nx = S_TLOAD;
                        end else begin
                           err      = 1'b1;
                           err_slot = 3'd4;
                        end
                     end
                  endcase
               end
               if (err) state_nx = S_TLOAD;
            end
         end
         S_TLOAD: state_nx = S_TMSG;
         S_TMSG: begin
            if (tx_go && msg_end)
               state_nx = res_q ? S_TDIG : S_TCR;
         end
         S_TDIG: begin
            if (tx_go && idx_last) state_nx = S_TCR;
         end
         S_TCR: begin
            if (tx_go) state_nx = S_TLF;
         end
         S_TLF: begin
            if (tx_go) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // datapath and outputs
   always_comb begin
      op_nx      = op_q;
      acc_nx     = acc_q;
      opnd_nx    = opnd_q;
      cnt_nx     = cnt_q;
      idx_nx     = idx_q;
      res_nx     = res_q;
      tx_rdy_nx  = tx_rdy_q;
      tx_data_nx = tx_data_q;
      addr_nx    = addr_q;

      if (state_q == S_IDLE && RX_DATA_EN && !rx_perr) begin
         if (is_add)       op_nx = OP_ADD;
         else if (is_sub)  op_nx = OP_SUB;
         else if (is_clr)  op_nx = OP_CLR;
         else if (is_show) op_nx = OP_SHOW;
      end

      if (dig) begin
         opnd_nx = (opnd_q << 4) | OPW'(DC_HEX_DATA);
         cnt_nx  = cnt_q + CW'(1);
      end

      if (err) begin
         addr_nx = {err_slot, {SLOT_LG{1'b0}}};
         opnd_nx = '0;
         cnt_nx  = '0;
         res_nx  = 1'b0;
      end

      if (exec) begin
         unique case (op_q)
            OP_ADD:  acc_nx = acc_q + W'(opnd_q);
            OP_SUB:  acc_nx = acc_q - W'(opnd_q);
            OP_CLR:  acc_nx = '0;
            default: acc_nx = acc_q;
         endcase
         res_nx  = 1'b1;
         addr_nx = '0;
         opnd_nx = '0;
         cnt_nx  = '0;
      end

      unique case (state_q)
         S_TLOAD: begin
            tx_data_nx = DATA;
            tx_rdy_nx  = 1'b1;
            addr_nx    = addr_q + AW'(1);
         end
         S_TMSG: begin
            if (tx_go) begin
               if (msg_end) begin
                  if (res_q) begin
                     tx_data_nx = DC_ASCII_DATA;
                     idx_nx     = CW'(1);
                  end else begin
                     tx_data_nx = 8'h0D;
                  end
               end else begin
                  tx_data_nx = DATA;
                  addr_nx    = addr_q + AW'(1);
               end
            end
         end
         S_TDIG: begin
            if (tx_go) begin
               if (idx_last) begin
                  tx_data_nx = 8'h0D;
                  idx_nx     = '0;
                  res_nx     = 1'b0;
               end else begin
                  tx_data_nx = DC_ASCII_DATA;
                  idx_nx     = idx_q + CW'(1);
               end
            end
         end
         S_TCR: begin
            if (tx_go) tx_data_nx = 8'h0A;
         end
         S_TLF: begin
            if (tx_go) tx_rdy_nx = 1'b0;
         end
         default: ;
      endcase
   end

   // MS nibble at index 0; indices past the last digit read as 0
   always_comb begin
      HEX_DATA = 4'h0;
      for (int i = 0; i <= N_DIGITS; i++) begin
         if (idx_q == CW'(i)) HEX_DATA = acc_q[4*(N_DIGITS-i) +: 4];
      end
   end

   assign ASCII_DATA = rx_b;
   assign TX_RDY_T   = tx_rdy_q;
   assign TX_DATA_T  = tx_data_q;
   assign ADDR       = addr_q;

endmodule

// File: tb/tb_hex_accum_fsm.sv
// tb_hex_accum_fsm: randomized and directed checks of hex_accum_fsm
// against a line-level model of the calculator (N_DIGITS=4, W=20).
module tb_hex_accum_fsm;

   localparam int ND = 4;
   localparam int SL = 4;
   localparam int AW = SL + 3;

   typedef logic [7:0] bq_t[$];

   logic          CLK;
   logic          RST_N;
   logic          RX_DATA_EN;
   logic [9:0]    RX_DATA_R;
   logic          HEX_FLG;
   logic [3:0]    DC_HEX_DATA;
   logic [7:0]    DC_ASCII_DATA;
   logic [7:0]    DATA;
   logic          TX_RDY_R;
   logic          TX_RDY_T;
   logic [7:0]    TX_DATA_T;
   logic [7:0]    ASCII_DATA;
   logic [3:0]    HEX_DATA;
   logic [AW-1:0] ADDR;

   logic [7:0]  rom [128];
   logic [19:0] acc_m;
   int          n_chk;
   int          n_fail;

   hex_accum_fsm #(.N_DIGITS(ND), .SLOT_LG(SL)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .RX_DATA_EN(RX_DATA_EN), .RX_DATA_R(RX_DATA_R),
      .HEX_FLG(HEX_FLG), .DC_HEX_DATA(DC_HEX_DATA),
      .DC_ASCII_DATA(DC_ASCII_DATA), .DATA(DATA),
      .TX_RDY_R(TX_RDY_R), .TX_RDY_T(TX_RDY_T),
      .TX_DATA_T(TX_DATA_T), .ASCII_DATA(ASCII_DATA),
      .HEX_DATA(HEX_DATA), .ADDR(ADDR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign DATA = rom[ADDR];

   // environment: hex decoder and ascii encoder
   always_comb begin
      HEX_FLG     = 1'b0;
      DC_HEX_DATA = 4'h0;
      if (ASCII_DATA >= "0" && ASCII_DATA <= "9") begin
         HEX_FLG = 1'b1; DC_HEX_DATA = 4'(ASCII_DATA - "0");
      end else if (ASCII_DATA >= "A" && ASCII_DATA <= "F") begin
         HEX_FLG = 1'b1; DC_HEX_DATA = 4'(ASCII_DATA - "A" + 10);
      end else if (ASCII_DATA >= "a" && ASCII_DATA <= "f") begin
         HEX_FLG = 1'b1; DC_HEX_DATA = 4'(ASCII_DATA - "a" + 10);
      end
   end

   always_comb begin
      if (HEX_DATA < 4'd10) DC_ASCII_DATA = 8'h30 + {4'h0, HEX_DATA};
      else                  DC_ASCII_DATA = 8'h37 + {4'h0, HEX_DATA};
   end

   function automatic void put(int slot, string s);
      for (int i = 0; i < s.len(); i++) rom[slot*16+i] = s[i];
   endfunction

   // message text as the spec defines it: up to first 00 or slot end
   function automatic bq_t msg(int slot);
      bq_t q;
      logic [7:0] b;
      q = {};
      for (int i = 0; i < 16; i++) begin
         b = rom[slot*16+i];
         if (b == 8'h00) begin
            if (i == 0) q.push_back(8'h00);
            break;
         end
         q.push_back(b);
      end
      return q;
   endfunction

   function automatic bq_t exp_err(int slot);
      bq_t q;
      q = msg(slot);
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   function automatic bq_t exp_res(logic [19:0] a);
      bq_t q;
      int  n;
      q = msg(0);
      for (int i = 4; i >= 0; i--) begin
         n = (int'(a) / (1 << (4*i))) % 16;
         q.push_back(8'(n < 10 ? 48 + n : 55 + n));
      end
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   function automatic string hexs(bq_t q);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   function automatic int hexval(logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c - "0");
      if (c >= "a" && c <= "f") return int'(c - "a") + 10;
      return int'(c - "A") + 10;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
      @(negedge CLK);
      RX_DATA_R  = {e, b};
      RX_DATA_EN = 1'b1;
      @(negedge CLK);
      RX_DATA_EN = 1'b0;
      @(negedge CLK);
   endtask

   task automatic send_q(input bq_t q);
      foreach (q[i]) send_byte(q[i], 2'b00);
   endtask

   task automatic line(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 2'b00);
      send_byte(8'h0D, 2'b00);
      send_byte(8'h0A, 2'b00);
   endtask

   task automatic pulse_rdy();
      repeat (2) @(negedge CLK);
      TX_RDY_R = 1'b1;
      @(negedge CLK);
      TX_RDY_R = 1'b0;
   endtask

   task automatic collect(output bq_t got, output bit to);
      int n;
      got = {};
      to  = 1'b0;
      n   = 0;
      while (TX_RDY_T !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if (TX_RDY_T !== 1'b1) begin
         to = 1'b1;
         return;
      end
      n = 0;
      while (TX_RDY_T === 1'b1 && n < 100) begin
         got.push_back(TX_DATA_T);
         pulse_rdy();
         n++;
      end
      if (n >= 100) to = 1'b1;
   endtask

   task automatic test_reset();
      RST_N      = 1'b0;
      RX_DATA_EN = 1'b0;
      RX_DATA_R  = {2'b00, "Q"};
      TX_RDY_R   = 1'b0;
      acc_m      = '0;
      repeat (3) @(negedge CLK);
      n_chk++;
      if (TX_RDY_T !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_tx_rdy got=%b exp=0", TX_RDY_T);
      end
      n_chk++;
      if (TX_DATA_T !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_tx_data got=%h exp=00", TX_DATA_T);
      end
      n_chk++;
      if (ADDR !== '0) begin
         n_fail++;
         $display("FAIL rst_addr got=%h exp=0", ADDR);
      end
      n_chk++;
      if (HEX_DATA !== 4'h0) begin
         n_fail++;
         $display("FAIL rst_hex got=%h exp=0", HEX_DATA);
      end
      n_chk++;
      if (ASCII_DATA !== 8'h51) begin
         n_fail++;
         $display("FAIL ascii_pass got=%h exp=51", ASCII_DATA);
      end
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_arith();
      bq_t got;
      bit  to;
      string ops[4] = '{"+1234", "-0235", "C", "-1"};
      int    vals[4] = '{'h1234, -'h235, 0, -1};
      foreach (ops[k]) begin
         line(ops[k]);
         if (ops[k] == "C") acc_m = '0;
         else acc_m = 20'(int'(acc_m) + vals[k]);
         collect(got, to);
         n_chk++;
         if (to || hexs(got) != hexs(exp_res(acc_m))) begin
            n_fail++;
            $display("FAIL arith_%s got=%s exp=%s to=%0d",
                     ops[k], hexs(got), hexs(exp_res(acc_m)), to);
         end
         n_chk++;
         if (TX_RDY_T !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_rdy_low got=%b exp=0", TX_RDY_T);
         end
      end
   endtask

   task automatic test_too_many();
      bq_t got;
      bit  to;
      bq_t pre = '{8'h2B, 8'h31, 8'h32, 8'h33, 8'h34};
      send_q(pre);
      send_byte("5", 2'b00);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(5))) begin
         n_fail++;
         $display("FAIL too_many got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(5)), to);
      end
      for (int k = 0; k < 2; k++) begin
         send_byte(k == 0 ? 8'h0D : 8'h0A, 2'b00);
         collect(got, to);
         n_chk++;
         if (to || hexs(got) != hexs(exp_err(4))) begin
            n_fail++;
            $display("FAIL crlf_idle_%0d got=%s exp=%s to=%0d",
                     k, hexs(got), hexs(exp_err(4)), to);
         end
      end
      line("=");
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_res(acc_m))) begin
         n_fail++;
         $display("FAIL acc_kept got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_res(acc_m)), to);
      end
   endtask

   task automatic test_errors();
      bq_t got;
      bit  to;
      send_byte("+", 2'b00);
      send_byte("1", 2'b00);
      send_byte("2", 2'b10);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(2))) begin
         n_fail++;
         $display("FAIL stop_err got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(2)), to);
      end
      send_byte("=", 2'b01);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(1))) begin
         n_fail++;
         $display("FAIL par_err got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(1)), to);
      end
      send_byte("x", 2'b11);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(3))) begin
         n_fail++;
         $display("FAIL both_err got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(3)), to);
      end
      send_byte("+", 2'b00);
      send_byte(8'h0D, 2'b00);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(6))) begin
         n_fail++;
         $display("FAIL empty_opnd got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(6)), to);
      end
      send_byte("x", 2'b00);
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_err(4))) begin
         n_fail++;
         $display("FAIL bad_char got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_err(4)), to);
      end
      line("=");
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_res(acc_m))) begin
         n_fail++;
         $display("FAIL err_acc_kept got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_res(acc_m)), to);
      end
   endtask

   task automatic test_drop();
      bq_t got;
      bit  to;
      line("=");
      fork
         collect(got, to);
         begin
            repeat (4) @(negedge CLK);
            send_byte("C", 2'b00);
            send_byte(8'h0D, 2'b00);
            send_byte(8'h0A, 2'b00);
         end
      join
      n_chk++;
      if (to || hexs(got) != hexs(exp_res(acc_m))) begin
         n_fail++;
         $display("FAIL drop_resp got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_res(acc_m)), to);
      end
      line("=");
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_res(acc_m))) begin
         n_fail++;
         $display("FAIL drop_after got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_res(acc_m)), to);
      end
   endtask

   task automatic test_random();
      bq_t   got, ln, exp;
      bit    to;
      string opc = "+-Cc=";
      string dgc = "0123456789abcdefABCDEF";
      logic [7:0] op;
      int    kind, nd, v, p;
      logic [1:0] e;
      for (int it = 0; it < 24; it++) begin
         op   = opc[$urandom_range(0, 4)];
         kind = $urandom_range(0, 9);
         ln   = {};
         ln.push_back(op);
         v    = 0;
         if (op == "+" || op == "-") begin
            nd = $urandom_range(1, ND);
            for (int d = 0; d < nd; d++) begin
               ln.push_back(dgc[$urandom_range(0, 21)]);
               v = v * 16 + hexval(ln[d+1]);
            end
         end
         if (kind == 0) begin
            ln.push_back("G");
            send_q(ln);
            exp = exp_err(4);
         end else if (kind == 1) begin
            ln.push_back(8'h0D);
            ln.push_back(8'h0A);
            p = $urandom_range(0, ln.size() - 1);
            e = 2'($urandom_range(1, 3));
            for (int i = 0; i < p; i++) send_byte(ln[i], 2'b00);
            send_byte(ln[p], e);
            exp = exp_err(int'(e));
         end else begin
            ln.push_back(8'h0D);
            ln.push_back(8'h0A);
            send_q(ln);
            if (op == "+") acc_m = 20'(int'(acc_m) + v);
            else if (op == "-") acc_m = 20'(int'(acc_m) - v);
            else if (op != "=") acc_m = '0;
            exp = exp_res(acc_m);
         end
         collect(got, to);
         n_chk++;
         if (to || hexs(got) != hexs(exp)) begin
            n_fail++;
            $display("FAIL rand_%0d kind=%0d got=%s exp=%s to=%0d",
                     it, kind, hexs(got), hexs(exp), to);
         end
      end
   endtask

   task automatic test_reset_mid();
      bq_t got;
      bit  to;
      int  n;
      line("=");
      n = 0;
      while (TX_RDY_T !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      n_chk++;
      if (TX_RDY_T !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_start got=%b exp=1", TX_RDY_T);
      end
      repeat (4) pulse_rdy();
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      n_chk++;
      if (TX_RDY_T !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_rdy got=%b exp=0", TX_RDY_T);
      end
      n_chk++;
      if (TX_DATA_T !== 8'h00 || ADDR !== '0) begin
         n_fail++;
         $display("FAIL mid_rst_regs got=%h/%h exp=00/00",
                  TX_DATA_T, ADDR);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      acc_m = '0;
      @(negedge CLK);
      line("=");
      collect(got, to);
      n_chk++;
      if (to || hexs(got) != hexs(exp_res(acc_m))) begin
         n_fail++;
         $display("FAIL mid_after got=%s exp=%s to=%0d",
                  hexs(got), hexs(exp_res(acc_m)), to);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      put(0, "R=");
      put(1, "PAR");
      put(2, "STOP");
      put(3, "PS");
      put(4, "BAD");
      put(5, "TOO MANY DIGITS!");
      put(7, "RSV");
      test_reset();
      test_arith();
      test_too_many();
      test_errors();
      test_drop();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
